pixel_write_queue: RTL and testbench

Buffers pixels produced by the edge rasterizer and writes them into the DE1 SRAM framebuffer. It clips off-screen pixels and computes the linear address y*640+x. It drains to SRAM only while video is blanked (iVIDEO_ON low) and backpressures the rasterizer when full. It sits directly downstream of the rasterizer and replaces the direct oMEM_ADDR/oMEM_WRITE/oGPU_DATA registers in the GPU top level.

---
 rtl/pixel_write_queue_if.sv | 28 ++
 rtl/pixel_write_queue.sv | 130 +++++++++++++
 tb/tb_pixel_write_queue.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_queue_if.sv
// Rasterizer-to-framebuffer bus: pixel handshake in, SRAM write strobe out.
// The master side is the rasterizer/display; the slave side is the queue.
interface pixel_write_queue_if #(
    parameter int ADDR_W = 18
);
    logic              iPIX_VALID;
    logic [15:0]       iPIX_X;
    logic [15:0]       iPIX_Y;
    logic [15:0]       iPIX_COLOR;
    logic              oPIX_READY;
    logic              iVIDEO_ON;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic [15:0]       oGPU_DATA;
    logic              oMEM_WRITE;
    logic              oMEM_READ;
    logic              oEMPTY;
    logic [15:0]       oCLIP_CNT;

    modport master (
        output iPIX_VALID, iPIX_X, iPIX_Y, iPIX_COLOR, iVIDEO_ON,
        input  oPIX_READY, oMEM_ADDR, oGPU_DATA, oMEM_WRITE, oMEM_READ, oEMPTY, oCLIP_CNT
    );

    modport slave (
        input  iPIX_VALID, iPIX_X, iPIX_Y, iPIX_COLOR, iVIDEO_ON,
        output oPIX_READY, oMEM_ADDR, oGPU_DATA, oMEM_WRITE, oMEM_READ, oEMPTY, oCLIP_CNT
    );
endinterface

// File: rtl/pixel_write_queue.sv
// Clips and queues rasterizer pixels, then writes them to the SRAM framebuffer
// only while video is blanked, using a SETUP/STROBE write cycle per pixel.
module pixel_write_queue #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 18
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    pixel_write_queue_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 16;
    localparam logic [31:0] SCREEN_W_U = SCREEN_W;
    localparam logic [31:0] SCREEN_H_U = SCREEN_H;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               ready_en_q;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        gpu_data_q, gpu_data_d;
    logic               mem_write_q;
    logic [15:0]        clip_cnt_q;

    logic               pix_ready, accept, in_bounds, push, pop, load;
    logic [ADDR_W-1:0]  push_addr;
    logic [ENTRY_W-1:0] push_entry, head_entry, next_head_entry, load_entry;

    assign pix_ready = ready_en_q && (count_q < CNT_W'(DEPTH));
    assign accept    = bus.iPIX_VALID && pix_ready;
    assign in_bounds = (32'(bus.iPIX_X) < SCREEN_W_U) && (32'(bus.iPIX_Y) < SCREEN_H_U);
    assign push      = accept && in_bounds;

    // Full-width product, then keep the low ADDR_W bits of the linear address.
    assign push_addr  = ADDR_W'(32'(bus.iPIX_Y) * SCREEN_W_U + 32'(bus.iPIX_X));
    assign push_entry = {push_addr, bus.iPIX_COLOR};

    // When the only queued entry pops while a new pixel lands, forward it directly.
    assign head_entry      = fifo_mem[rd_ptr_q];
    assign next_head_entry = (count_q > CNT_W'(1)) ? fifo_mem[rd_ptr_q + PTR_W'(1)] : push_entry;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_entry = head_entry;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !bus.iVIDEO_ON) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                state_d = bus.iVIDEO_ON ? IDLE : STROBE;
            end
            STROBE: begin
                pop = 1'b1;
                if ((count_q > CNT_W'(1) || push) && !bus.iVIDEO_ON) begin
                    state_d    = SETUP;
                    load       = 1'b1;
                    load_entry = next_head_entry;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        gpu_data_d = gpu_data_q;
        if (load) begin
            mem_addr_d = load_entry[ENTRY_W-1:16];
            gpu_data_d = load_entry[15:0];
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            mem_addr_q  <= '0;
            gpu_data_q  <= '0;
            mem_write_q <= 1'b0;
            clip_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            mem_addr_q  <= mem_addr_d;
            gpu_data_q  <= gpu_data_d;
            mem_write_q <= (state_d == STROBE);
            count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept && !in_bounds && clip_cnt_q != 16'hFFFF) begin
                clip_cnt_q <= clip_cnt_q + 16'd1;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.oPIX_READY = pix_ready;
    assign bus.oMEM_ADDR  = mem_addr_q;
    assign bus.oGPU_DATA  = gpu_data_q;
    assign bus.oMEM_WRITE = mem_write_q;
    assign bus.oMEM_READ  = 1'b0;
    assign bus.oEMPTY     = (count_q == '0) && (state_q == IDLE);
    assign bus.oCLIP_CNT  = clip_cnt_q;
endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench: a queue-level scoreboard checks every cycle, and
// directed scenarios pin latency, backpressure, clipping, aborts and reset.
`timescale 1ns/1ps
module tb_pixel_write_queue;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_write_queue_if #(.ADDR_W(18)) bus ();

    pixel_write_queue #(
        .DEPTH(16), .SCREEN_W(640), .SCREEN_H(480), .ADDR_W(18)
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Queue-level model: what has been accepted, in order, and how much is held.
    int          occ      = 0;
    int          clip_m   = 0;
    int          expa[$];
    int          expd[$];
    logic        started  = 1'b0;
    logic        ready_ok = 1'b0;
    logic        vid_edge = 1'b0;
    logic        wr_prev  = 1'b0;
    logic        push_in, in_b;

    assign push_in = bus.iPIX_VALID && bus.oPIX_READY;
    assign in_b    = (bus.iPIX_X < 16'd640) && (bus.iPIX_Y < 16'd480);

    always @(posedge clk) begin
        started  <= 1'b1;
        ready_ok <= rst_n;
        vid_edge <= bus.iVIDEO_ON;
        wr_prev  <= bus.oMEM_WRITE;
        if (!rst_n) begin
            occ    <= 0;
            clip_m <= 0;
            expa.delete();
            expd.delete();
        end else begin
            occ <= occ + ((push_in && in_b) ? 1 : 0) - (bus.oMEM_WRITE ? 1 : 0);
            if (bus.oMEM_WRITE && expa.size() > 0) begin
                void'(expa.pop_front());
                void'(expd.pop_front());
            end
            if (push_in && in_b) begin
                expa.push_back((int'(bus.iPIX_Y) * 640 + int'(bus.iPIX_X)) % 262144);
                expd.push_back(int'(bus.iPIX_COLOR));
            end
            if (push_in && !in_b && clip_m < 65535) begin
                clip_m <= clip_m + 1;
            end
        end
    end

    task automatic compare_cycle();
        chk("mem_read", 32'(bus.oMEM_READ), 0);
        chk("ready", 32'(bus.oPIX_READY), 32'(ready_ok && occ < DEPTH));
        chk("empty", 32'(bus.oEMPTY), 32'(occ == 0));
        chk("clip_cnt", 32'(bus.oCLIP_CNT), 32'(clip_m));
        if (bus.oMEM_WRITE) begin
            chk("write_has_entry", 32'(expa.size() > 0), 1);
            if (expa.size() > 0) begin
                chk("write_addr", 32'(bus.oMEM_ADDR), 32'(expa[0]));
                chk("write_data", 32'(bus.oGPU_DATA), 32'(expd[0]));
            end
            chk("strobe_single_cycle", 32'(wr_prev), 0);
            chk("strobe_video_off", 32'(vid_edge), 0);
        end
    endtask

    int   w_idx[$];
    int   w_addr[$];
    int   w_data[$];
    int   rdy_first;

    task automatic watch(input int n);
        w_idx.delete();
        w_addr.delete();
        w_data.delete();
        rdy_first = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.oMEM_WRITE) begin
                w_idx.push_back(i);
                w_addr.push_back(int'(bus.oMEM_ADDR));
                w_data.push_back(int'(bus.oGPU_DATA));
            end
            if (rdy_first < 0 && bus.oPIX_READY) rdy_first = i;
        end
    endtask

    task automatic push_px(input int x, input int y, input logic [15:0] c, output bit acc);
        bus.iPIX_VALID = 1'b1;
        bus.iPIX_X     = 16'(x);
        bus.iPIX_Y     = 16'(y);
        bus.iPIX_COLOR = c;
        acc            = bus.oPIX_READY;
        @(posedge clk);
        #1;
        bus.iPIX_VALID = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready_low", 32'(bus.oPIX_READY), 0);
        chk("rst_write", 32'(bus.oMEM_WRITE), 0);
        chk("rst_empty", 32'(bus.oEMPTY), 1);
        chk("rst_addr", 32'(bus.oMEM_ADDR), 0);
        chk("rst_data", 32'(bus.oGPU_DATA), 0);
        chk("rst_clip", 32'(bus.oCLIP_CNT), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 32'(bus.oPIX_READY), 1);
    endtask

    initial begin
        bit acc;
        int acc_cnt;
        bus.iPIX_VALID = 1'b0;
        bus.iPIX_X     = '0;
        bus.iPIX_Y     = '0;
        bus.iPIX_COLOR = '0;
        bus.iVIDEO_ON  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (started) compare_cycle();
            end
        join_none

        // Single pixel: (5,2) -> 2*640+5 = 1285, strobe in the 3rd cycle after the push edge.
        do_reset();
        push_px(5, 2, 16'hF800, acc);
        watch(8);
        chk("t1_write_count", 32'(w_idx.size()), 1);
        if (w_idx.size() > 0) begin
            chk("t1_latency", 32'(w_idx[0]), 3);
            chk("t1_addr", 32'(w_addr[0]), 1285);
            chk("t1_data", 32'(w_data[0]), 32'h0000F800);
        end
        chk("t1_empty", 32'(bus.oEMPTY), 1);
        $display("T1 single pixel: writes=%0d", w_idx.size());

        // Backpressure: 20 offered with video on, 16 fit; then drain at 2 cycles each.
        do_reset();
        bus.iVIDEO_ON = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            push_px(i, 10, 16'h1000 + 16'(i), acc);
            if (acc) acc_cnt++;
        end
        chk("t2_accepted", 32'(acc_cnt), 16);
        chk("t2_ready_full", 32'(bus.oPIX_READY), 0);
        watch(4);
        chk("t2_no_write_video_on", 32'(w_idx.size()), 0);
        bus.iVIDEO_ON = 1'b0;
        watch(40);
        chk("t2_write_count", 32'(w_idx.size()), 16);
        if (w_idx.size() == 16) begin
            chk("t2_first_write", 32'(w_idx[0]), 2);
            chk("t2_ready_rise", 32'(rdy_first), 3);
            for (int i = 0; i < 16; i++) begin
                chk("t2_addr", 32'(w_addr[i]), 32'(6400 + i));
                chk("t2_data", 32'(w_data[i]), 32'(32'h1000 + i));
                if (i > 0) chk("t2_spacing", 32'(w_idx[i] - w_idx[i-1]), 2);
            end
        end
        $display("T2 backpressure: accepted=%0d writes=%0d", acc_cnt, w_idx.size());

        // Clipping: two off-screen, one at (479*640+639) mod 2^18 = 45055.
        do_reset();
        push_px(640, 0, 16'h1111, acc);
        push_px(0, 480, 16'h2222, acc);
        push_px(639, 479, 16'h07E0, acc);
        watch(10);
        chk("t3_clip_cnt", 32'(bus.oCLIP_CNT), 2);
        chk("t3_write_count", 32'(w_idx.size()), 1);
        if (w_idx.size() > 0) begin
            chk("t3_addr", 32'(w_addr[0]), 45055);
            chk("t3_data", 32'(w_data[0]), 32'h07E0);
        end
        $display("T3 clipping: clip=%0d writes=%0d", bus.oCLIP_CNT, w_idx.size());

        // Video-on during SETUP aborts without a strobe; same entry written later.
        do_reset();
        push_px(1, 1, 16'hAAAA, acc);
        @(negedge clk);
        @(negedge clk);
        chk("t4_setup_addr", 32'(bus.oMEM_ADDR), 641);
        chk("t4_setup_no_write", 32'(bus.oMEM_WRITE), 0);
        bus.iVIDEO_ON = 1'b1;
        watch(6);
        chk("t4_abort_no_write", 32'(w_idx.size()), 0);
        bus.iVIDEO_ON = 1'b0;
        watch(6);
        chk("t4_retry_count", 32'(w_idx.size()), 1);
        if (w_idx.size() > 0) begin
            chk("t4_retry_addr", 32'(w_addr[0]), 641);
            chk("t4_retry_data", 32'(w_data[0]), 32'hAAAA);
            chk("t4_retry_latency", 32'(w_idx[0]), 2);
        end
        // Video-on during STROBE: strobe completes, next entry waits.
        bus.iVIDEO_ON = 1'b1;
        push_px(2, 1, 16'hBBBB, acc);
        push_px(3, 1, 16'hCCCC, acc);
        @(negedge clk);
        bus.iVIDEO_ON = 1'b0;
        watch(2);
        chk("t4_strobe_count", 32'(w_idx.size()), 1);
        if (w_idx.size() > 0) chk("t4_strobe_addr", 32'(w_addr[0]), 642);
        bus.iVIDEO_ON = 1'b1;
        watch(6);
        chk("t4_wait_no_write", 32'(w_idx.size()), 0);
        bus.iVIDEO_ON = 1'b0;
        watch(6);
        chk("t4_next_count", 32'(w_idx.size()), 1);
        if (w_idx.size() > 0) chk("t4_next_addr", 32'(w_addr[0]), 643);
        $display("T4 video abort: done");

        // Push and pop on the same edge at DEPTH-1 keep the count at DEPTH-1.
        do_reset();
        bus.iVIDEO_ON = 1'b1;
        for (int i = 0; i < 15; i++) push_px(100 + i, 3, 16'h5000 + 16'(i), acc);
        @(negedge clk);
        bus.iVIDEO_ON = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_strobe", 32'(bus.oMEM_WRITE), 1);
        push_px(200, 3, 16'h5555, acc);
        chk("t5_push_accepted", 32'(acc), 1);
        @(negedge clk);
        chk("t5_ready_at_15", 32'(bus.oPIX_READY), 1);
        push_px(201, 3, 16'h5556, acc);
        @(negedge clk);
        chk("t5_ready_at_16", 32'(bus.oPIX_READY), 0);
        watch(40);
        chk("t5_write_count", 32'(w_idx.size()), 15);
        if (w_idx.size() == 15) begin
            chk("t5_addr_pen", 32'(w_addr[13]), 2120);
            chk("t5_addr_last", 32'(w_addr[14]), 2121);
            chk("t5_data_last", 32'(w_data[14]), 32'h5556);
        end
        $display("T5 push/pop at DEPTH-1: writes=%0d", w_idx.size());

        // Reset in the middle of a strobe drops it at once and clears everything.
        do_reset();
        push_px(700, 0, 16'h0000, acc);
        push_px(7, 0, 16'h7777, acc);
        push_px(8, 0, 16'h7778, acc);
        @(negedge clk);
        @(negedge clk);
        chk("t6_strobe", 32'(bus.oMEM_WRITE), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_write_dropped", 32'(bus.oMEM_WRITE), 0);
        chk("t6_empty", 32'(bus.oEMPTY), 1);
        chk("t6_clip", 32'(bus.oCLIP_CNT), 0);
        rst_n = 1'b1;
        watch(6);
        chk("t6_no_write_after", 32'(w_idx.size()), 0);
        chk("t6_ready", 32'(bus.oPIX_READY), 1);
        $display("T6 reset mid-strobe: done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
